// File: rtl/dffs_refill_ctrl.sv
// Refill controller feeding the DFF-based masked dual-port array: collects a critical-word-first line
// and commits it through the bulk write port. Define DFFS_REFILL_STREAM_EN to write each beat as it arrives.
module dffs_refill_ctrl #(
    parameter int SIZE = 2,
    parameter int WLEN = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic [SIZE-1:0]              REQ_FIRST,
    input  logic                         BEAT_VALID,
    output logic                         BEAT_READY,
    input  logic [WLEN-1:0]              BEAT_DATA,
    input  logic                         BEAT_ERR,
    output logic                         CRIT_VALID,
    output logic [WLEN-1:0]              CRIT_DATA,
    output logic [(2**SIZE)-1:0]         WENB,
    output logic [WLEN*(2**SIZE)-1:0]    DB,
    output logic [(2**SIZE)-1:0]         MASK,
    output logic                         DONE,
    output logic                         ERR,
    output logic                         BUSY
);

    localparam int WORDS = 2**SIZE;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]      state;
    logic [SIZE-1:0] ptr;
    logic [SIZE-1:0] cnt;
    logic            err_flag;

    // Handshake readies come straight from the state register, so no output sees an input combinationally.
    assign REQ_READY  = (state == IDLE);
    assign BEAT_READY = (state == FILL);
    assign BUSY       = (state != IDLE);

`ifndef DFFS_REFILL_STREAM_EN
    logic [WLEN*WORDS-1:0] staging;
    logic [WLEN*WORDS-1:0] next_line;

    // Line image including the beat being accepted this cycle, so the last beat commits without an extra cycle.
    always_comb begin
        next_line = staging;
        next_line[int'(ptr)*WLEN +: WLEN] = BEAT_DATA;
    end
`endif

    // NOTE: all state here is sequential and updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            err_flag   <= 1'b0;
            CRIT_VALID <= 1'b0;
            CRIT_DATA  <= '0;
            WENB       <= '1;
            MASK       <= '0;
            DB         <= '0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
`ifndef DFFS_REFILL_STREAM_EN
            // NOTE: the staging buffer is reset on purpose so an aborted refill leaves no stale words behind.
            staging    <= '0;
`endif
        end else begin
            CRIT_VALID <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            WENB       <= '1;
            MASK       <= '0;
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        ptr      <= REQ_FIRST;
                        cnt      <= '0;
                        err_flag <= 1'b0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (BEAT_VALID) begin
                        ptr      <= ptr + 1'b1;
                        cnt      <= cnt + 1'b1;
                        err_flag <= err_flag | BEAT_ERR;
                        if (cnt == '0) begin
                            CRIT_VALID <= 1'b1;
                            CRIT_DATA  <= BEAT_DATA;
                        end
`ifdef DFFS_REFILL_STREAM_EN
                        WENB[ptr]                      <= 1'b0;
                        MASK[ptr]                      <= 1'b1;
                        DB[int'(ptr)*WLEN +: WLEN]     <= BEAT_DATA;
`else
                        staging <= next_line;
`endif
                        if (&cnt) begin
                            state <= COMMIT;
                            DONE  <= 1'b1;
                            ERR   <= err_flag | BEAT_ERR;
`ifndef DFFS_REFILL_STREAM_EN
                            // An errored line is dropped whole; DB keeps its previous image.
                            if (!(err_flag | BEAT_ERR)) begin
                                WENB <= '0;
                                MASK <= '1;
                                DB   <= next_line;
                            end
`endif
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dffs_refill_ctrl.md
Name: dffs_refill_ctrl

Overview:
- Upstream fill stage for the team's DFF-based masked dual-port array.
- Accepts a refill request with a critical-word-first start index, then collects 2**SIZE single-word beats from a valid/ready bus.
- Wraps the word index modulo 2**SIZE.
- Drives the array's bulk write port (per-word active-low WENB, full-width DB, per-word MASK) with the assembled line, and forwards the critical word early.

Parameters:
- SIZE, 2, log2 of words per line (array depth); must be ≥1.
- WLEN, 32, word width in bits.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, asynchronous, active-low.
- REQ_VALID  input  1  refill request.
- REQ_READY  output  1  request accepted when REQ_VALID && REQ_READY.
- REQ_FIRST  input  SIZE  word index of the first beat (critical word).
- BEAT_VALID  input  1  beat present.
- BEAT_READY  output  1  beat consumed when BEAT_VALID && BEAT_READY.
- BEAT_DATA  input  WLEN  beat payload.
- BEAT_ERR  input  1  beat carries a bus error; sampled with the beat.
- CRIT_VALID  output  1  one-cycle pulse: critical word available.
- CRIT_DATA  output  WLEN  critical word; held until the next request.
- WENB  output  2**SIZE  per-word write enable to the array, active-low.
- DB  output  WLEN*(2**SIZE)  line image; word i at bits [i*WLEN +: WLEN].
- MASK  output  2**SIZE  per-word commit mask; nonzero only in write cycles.
- DONE  output  1  one-cycle pulse: refill finished.
- ERR  output  1  qualifies DONE: at least one beat had BEAT_ERR.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, REQ_READY=1, BEAT_READY=0, WENB all-ones, MASK=0, DB=0, CRIT_VALID=0, CRIT_DATA=0, DONE=0, ERR=0, BUSY=0.
- Reset asserted mid-refill aborts immediately: no write is issued and the staging buffer is cleared.
- All outputs are registered; none depend combinationally on inputs.
- States: IDLE, FILL, COMMIT.
- IDLE:
  - REQ_READY=1, BEAT_READY=0.
  - On request: latch ptr=REQ_FIRST, beat count cnt=0, sticky error flag=0; go to FILL.
  - Beats presented in IDLE are not consumed.
- FILL:
  - REQ_READY=0, BEAT_READY=1.
  - Each accepted beat writes staging[ptr]=BEAT_DATA, ORs BEAT_ERR into the error flag, then ptr=ptr+1 mod 2**SIZE and cnt=cnt+1.
  - cnt==0 beat: cycle after acceptance, CRIT_VALID=1 and CRIT_DATA=BEAT_DATA (even if errored).
  - When beat cnt==2**SIZE-1 is accepted: go to COMMIT next cycle; BEAT_READY=0 from that cycle.
  - BEAT_VALID low stalls with no state change; there is no timeout.
- COMMIT (exactly one cycle):
  - No error: WENB all-zeros, MASK all-ones, DB=staging.
  - Error: WENB all-ones, MASK=0, so the line is not written.
  - DONE=1 and ERR=error flag in this cycle; return to IDLE next cycle.
- REQ_READY rises the cycle after COMMIT.
- A REQ_VALID held through BUSY is accepted on the first IDLE cycle; no back-to-back overlap.
- Minimum refill latency, request to DONE: 2**SIZE+1 cycles.
- DB holds its last value outside write cycles; the array ignores it because WENB is high.

Optional Feature:
- Macro: DFFS_REFILL_STREAM_EN.
- Defined:
  - No staging buffer; each accepted beat is written the following cycle with WENB[ptr]=0, MASK[ptr]=1, DB word ptr=BEAT_DATA, all other WENB bits 1.
  - The last write coincides with the COMMIT cycle, which asserts DONE.
  - Errored beats are still written (words already written stay valid); ERR is reported at DONE.
- Undefined: buffered single-cycle commit as above.

Test Plan (SIZE=2, WLEN=32):
- Request with REQ_FIRST=2, beats A,B,C,D back-to-back, no error -> CRIT_VALID one cycle after A with CRIT_DATA=A. COMMIT: words 2,3,0,1 = A,B,C,D, WENB=4'b0000, MASK=4'b1111, DONE=1, ERR=0, 5 cycles after the request.
- REQ_FIRST=0, BEAT_VALID deasserted 3 cycles between beats 1 and 2 -> no ptr advance while stalled, line correct, DONE delayed by exactly 3 cycles.
- BEAT_ERR=1 on beat 3 -> COMMIT has WENB=4'b1111, MASK=0, DONE=1, ERR=1; next request completes with ERR=0.
- RST low after 2 beats -> all outputs at reset values, no WENB activity; a new request afterwards completes normally.
- REQ_VALID held high through a refill -> second request accepted on the first IDLE cycle, REQ_READY=0 throughout BUSY.
- DFFS_REFILL_STREAM_EN defined, REQ_FIRST=3 -> WENB sequence 0111, 1110, 1101, 1011 on consecutive cycles; DONE with the last write.
